// File: rtl/alu_microsequencer.sv
// alu_microsequencer
//
// Issue controller sitting between instruction decode and register-file
// writeback. It takes one operation request at a time, drives the external
// 16-bit ALU (op 00 ADD, 01 SUB, 10 NAND, 11 OR) through one or more
// single-cycle passes, and returns a registered result with a zero flag.
// XOR is built from four NAND passes and SHL from repeated ADD-to-self
// passes, since neither has a native ALU encoding.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_ready is high only in IDLE
//   req_opcode            000 ADD, 001 SUB, 010 NAND, 011 OR,
//                         100 CMP, 101 XOR, 110 SHL, 111 NOP
//   req_a, req_b          operands; SHL uses req_b[3:0] as the shift count
//   alu_in1/alu_in2/alu_op  registered ALU operands and operation select
//   alu_out, alu_zero     combinational ALU result and zero flag
//   rsp_valid/rsp_ready   response handshake
//   rsp_data, rsp_zero    result and zero flag
//   rsp_wb                writeback enable (0 for CMP and NOP)
//
// Timing: a request accepted at edge T runs its N passes in the N cycles
// after T; one further cycle registers the response, so rsp_valid rises
// after edge T+N+1.

module alu_microsequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_opcode,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic [1:0]  alu_op,
    input  logic [15:0] alu_out,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_zero,
    output logic        rsp_wb
);

    localparam int DATA_W = 16;

    localparam logic [2:0] OPC_ADD  = 3'b000;
    localparam logic [2:0] OPC_SUB  = 3'b001;
    localparam logic [2:0] OPC_NAND = 3'b010;
    localparam logic [2:0] OPC_OR   = 3'b011;
    localparam logic [2:0] OPC_CMP  = 3'b100;
    localparam logic [2:0] OPC_XOR  = 3'b101;
    localparam logic [2:0] OPC_SHL  = 3'b110;
    localparam logic [2:0] OPC_NOP  = 3'b111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2:0]        opc_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] t_q, u_q;      // XOR intermediates a~&b and a~&t
    logic [DATA_W-1:0] res_q;         // most recent alu_out sample
    logic              zflag_q;       // alu_zero sampled with res_q
    logic [3:0]        cnt_q;         // passes completed so far
    logic [3:0]        npass_q;       // passes this operation needs
    logic              exec_done;
    logic              last_pass;

    // Number of ALU passes for an opcode; SHL by zero still needs one pass.
    function automatic logic [3:0] pass_count(input logic [2:0] opcode,
                                              input logic [3:0] k);
        case (opcode)
            OPC_XOR: pass_count = 4'd4;
            OPC_SHL: pass_count = (k == 4'd0) ? 4'd1 : k;
            default: pass_count = 4'd1;
        endcase
    endfunction

    // The ALU zero flag is only trusted on SUB passes; everything else
    // derives its flag from the result locally.
    function automatic logic resp_zero_flag(input logic [2:0]        opcode,
                                            input logic [DATA_W-1:0] result,
                                            input logic              sub_zero);
        case (opcode)
            OPC_SUB, OPC_CMP: resp_zero_flag = sub_zero;
            OPC_NOP:          resp_zero_flag = 1'b1;
            default:          resp_zero_flag = (result == '0);
        endcase
    endfunction

    assign exec_done = (cnt_q == npass_q);
    assign last_pass = ((cnt_q + 4'd1) == npass_q);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (req_valid) state_next = S_EXEC;
            S_EXEC: if (exec_done) state_next = S_RESP;
            S_RESP: if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
    end

    // Datapath: operand latching, pass sequencing and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q    <= OPC_ADD;
            a_q      <= '0;
            b_q      <= '0;
            t_q      <= '0;
            u_q      <= '0;
            res_q    <= '0;
            zflag_q  <= 1'b0;
            cnt_q    <= 4'd0;
            npass_q  <= 4'd0;
            alu_in1  <= '0;
            alu_in2  <= '0;
            alu_op   <= ALU_ADD;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
            rsp_wb   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        opc_q   <= req_opcode;
                        a_q     <= req_a;
                        b_q     <= req_b;
                        t_q     <= '0;
                        u_q     <= '0;
                        res_q   <= '0;
                        zflag_q <= 1'b0;
                        cnt_q   <= 4'd0;
                        npass_q <= pass_count(req_opcode, req_b[3:0]);
                        // First pass operands go out on the accepting edge.
                        case (req_opcode)
                            OPC_ADD, OPC_SUB, OPC_NAND, OPC_OR: begin
                                alu_in1 <= req_a;
                                alu_in2 <= req_b;
                                alu_op  <= req_opcode[1:0];
                            end
                            OPC_CMP: begin
                                alu_in1 <= req_a;
                                alu_in2 <= req_b;
                                alu_op  <= ALU_SUB;
                            end
                            OPC_XOR: begin
                                alu_in1 <= req_a;
                                alu_in2 <= req_b;
                                alu_op  <= ALU_NAND;
                            end
                            OPC_SHL: begin
                                // a+a doubles; k=0 passes a through as a+0.
                                alu_in1 <= req_a;
                                alu_in2 <= (req_b[3:0] == 4'd0) ? '0 : req_a;
                                alu_op  <= ALU_ADD;
                            end
                            default: begin
                                alu_in1 <= '0;
                                alu_in2 <= '0;
                                alu_op  <= ALU_ADD;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    if (!exec_done) begin
                        cnt_q   <= cnt_q + 4'd1;
                        res_q   <= alu_out;
                        zflag_q <= alu_zero;
                        // Next pass operands are loaded on the same edge that
                        // samples this pass; the final pass leaves them as-is.
                        case (opc_q)
                            OPC_XOR: begin
                                case (cnt_q)
                                    4'd0: begin
                                        t_q     <= alu_out;
                                        alu_in1 <= a_q;
                                        alu_in2 <= alu_out;
                                    end
                                    4'd1: begin
                                        u_q     <= alu_out;
                                        alu_in1 <= b_q;
                                        alu_in2 <= t_q;
                                    end
                                    4'd2: begin
                                        alu_in1 <= u_q;
                                        alu_in2 <= alu_out;
                                    end
                                    default: ;
                                endcase
                            end
                            OPC_SHL: begin
                                if (!last_pass) begin
                                    alu_in1 <= alu_out;
                                    alu_in2 <= alu_out;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        rsp_data <= (opc_q == OPC_NOP) ? '0 : res_q;
                        rsp_zero <= resp_zero_flag(opc_q, res_q, zflag_q);
                        rsp_wb   <= (opc_q != OPC_CMP) && (opc_q != OPC_NOP);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_microsequencer.sv
// Testbench for alu_microsequencer: a behavioural ALU drives alu_out /
// alu_zero (alu_zero carries noise outside SUB passes), a table of directed
// vectors plus randomized operations are checked against a plain-arithmetic
// reference, and hand-written sequences cover XOR pass operands and reset
// abort.

module tb_alu_microsequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_opcode;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [1:0]  alu_op;
    logic [15:0] alu_out;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_wb;

    int checks = 0;
    int failures = 0;
    logic noise = 1'b0;

    alu_microsequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_wb     (rsp_wb)
    );

    always #5 clk = ~clk;

    always @(negedge clk) noise <= 1'($urandom_range(0, 1));

    // Behavioural ALU; the zero flag is only meaningful on SUB.
    always_comb begin
        case (alu_op)
            2'b00:   alu_out = alu_in1 + alu_in2;
            2'b01:   alu_out = alu_in1 - alu_in2;
            2'b10:   alu_out = ~(alu_in1 & alu_in2);
            default: alu_out = alu_in1 | alu_in2;
        endcase
        alu_zero = (alu_op == 2'b01) ? (alu_out == 16'h0000) : noise;
    end

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        z;
        logic        w;
        int          lat;
        int          hold;
    } vec_t;

    vec_t tbl [13];

    // Reference model: results from the operation's meaning, not its passes.
    function automatic logic [15:0] ref_data(input logic [2:0] op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
        logic [15:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = ~(a & b);
            3'd3: r = a | b;
            3'd4: r = a - b;
            3'd5: r = a ^ b;
            3'd6: r = a << b[3:0];
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [15:0] b);
        int n;
        if (op == 3'd5) n = 4;
        else if (op == 3'd6) n = (b[3:0] == 4'd0) ? 1 : int'(b[3:0]);
        else n = 1;
        return n + 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ed, input logic ez, input logic ew,
                          input int elat, input int hold);
        int lat;
        bit seen;
        logic [15:0] d0;
        @(negedge clk);
        check({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_opcode = op;
        req_a      = a;
        req_b      = b;
        @(posedge clk);
        #1;
        lat = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            // Junk on the request port must be ignored while busy.
            req_valid  = 1'($urandom_range(0, 1));
            req_opcode = 3'($urandom);
            req_a      = 16'($urandom);
            req_b      = 16'($urandom);
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) seen = 1;
        end
        req_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        if (!seen) return;
        check({tag, "_data"}, 32'(rsp_data), 32'(ed));
        check({tag, "_zero"}, 32'(rsp_zero), 32'(ez));
        check({tag, "_wb"}, 32'(rsp_wb), 32'(ew));
        d0 = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_data"}, 32'(rsp_data), 32'(d0));
            check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ready_after_hs"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] xa, xb, xt, xu, xv;
        logic [15:0] e1 [4];
        logic [15:0] e2 [4];
        bit spurious;

        tbl[0]  = '{3'd0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b1, 2, 0};
        tbl[1]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 2, 0};
        tbl[2]  = '{3'd1, 16'h00AA, 16'h00AA, 16'h0000, 1'b1, 1'b1, 2, 0};
        tbl[3]  = '{3'd4, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 2, 0};
        tbl[4]  = '{3'd5, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0, 1'b1, 5, 0};
        tbl[5]  = '{3'd6, 16'h0003, 16'h0004, 16'h0030, 1'b0, 1'b1, 5, 0};
        tbl[6]  = '{3'd6, 16'h8001, 16'h0010, 16'h8001, 1'b0, 1'b1, 2, 0};
        tbl[7]  = '{3'd6, 16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b1, 2, 0};
        tbl[8]  = '{3'd2, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 2, 0};
        tbl[9]  = '{3'd3, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b1, 2, 3};
        tbl[10] = '{3'd7, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 2, 0};
        tbl[11] = '{3'd6, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b1, 16, 0};
        tbl[12] = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 2, 1};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_opcode = 3'd0;
        req_a      = 16'h0;
        req_b      = 16'h0;
        rsp_ready  = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        check("rst_rsp_wb", 32'(rsp_wb), 32'd0);
        check("rst_alu_in1", 32'(alu_in1), 32'd0);
        check("rst_alu_in2", 32'(alu_in2), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].d, tbl[i].z, tbl[i].w, tbl[i].lat, tbl[i].hold);
        end

        // XOR: operands and op of each of the four NAND passes
        xa = 16'hF0F0;
        xb = 16'h0FF0;
        xt = ~(xa & xb);
        xu = ~(xa & xt);
        xv = ~(xb & xt);
        e1[0] = xa; e2[0] = xb;
        e1[1] = xa; e2[1] = xt;
        e1[2] = xb; e2[2] = xt;
        e1[3] = xu; e2[3] = xv;
        @(negedge clk);
        req_valid  = 1'b1;
        req_opcode = 3'd5;
        req_a      = xa;
        req_b      = xb;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            check($sformatf("xor_pass%0d_op", p), 32'(alu_op), 32'd2);
            check($sformatf("xor_pass%0d_in1", p), 32'(alu_in1), 32'(e1[p]));
            check($sformatf("xor_pass%0d_in2", p), 32'(alu_in2), 32'(e2[p]));
            @(posedge clk);
            #1;
        end
        check("xor_not_early", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check("xor_valid_t5", 32'(rsp_valid), 32'd1);
        check("xor_data", 32'(rsp_data), 32'(xa ^ xb));
        check("xor_zero", 32'(rsp_zero), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Reset during XOR pass 2 aborts the operation
        run_op("pre_rst_add", 3'd0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b1, 2, 0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_opcode = 3'd5;
        req_a      = 16'hF0F0;
        req_b      = 16'h0FF0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_data", 32'(rsp_data), 32'd0);
        check("abort_rsp_zero", 32'(rsp_zero), 32'd0);
        check("abort_rsp_wb", 32'(rsp_wb), 32'd0);
        check("abort_alu_in1", 32'(alu_in1), 32'd0);
        check("abort_alu_in2", 32'(alu_in2), 32'd0);
        check("abort_alu_op", 32'(alu_op), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) spurious = 1;
        end
        check("abort_no_response", 32'(spurious), 32'd0);
        run_op("post_rst_nand", 3'd2, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 2, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [15:0] a, b, d;
            op = 3'($urandom);
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b = a;
            if (op == 3'd6 && $urandom_range(0, 2) == 0) b[3:0] = 4'd0;
            d = ref_data(op, a, b);
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, d,
                   (op == 3'd7) ? 1'b1 : (d == 16'h0000),
                   (op != 3'd4) && (op != 3'd7),
                   ref_lat(op, b), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_microsequencer.md
# alu_microsequencer

Multi-cycle issue controller that drives the 16-bit ALU (2-bit op: 00 ADD, 01 SUB, 10 NAND, 11 OR) from the initiator side. It accepts one operation request at a time, sequences one or more single-cycle ALU passes, and returns a registered result with a zero flag. XOR and left-shift have no native ALU encoding, so they are built from multiple NAND or ADD passes. The block sits between instruction decode and register-file writeback.

## Interface
- No parameters; datapath width fixed at 16.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_opcode  in  3  000 ADD, 001 SUB, 010 NAND, 011 OR, 100 CMP, 101 XOR, 110 SHL, 111 NOP.
- req_a  in  16  operand A.
- req_b  in  16  operand B; for SHL, only b[3:0] is used as the shift count k.
- alu_in1  out  16  ALU operand 1 (registered).
- alu_in2  out  16  ALU operand 2 (registered).
- alu_op  out  2  ALU operation select (registered).
- alu_out  in  16  combinational ALU result.
- alu_zero  in  1  ALU zero flag; meaningful only on SUB passes.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  16  result.
- rsp_zero  out  1  zero flag.
- rsp_wb  out  1  writeback enable: 0 for CMP and NOP, else 1.

## Operation
- States: IDLE, EXEC, RESP.
  - IDLE: on req_valid && req_ready, latch a, b, opcode and k; load the first-pass alu_in1/alu_in2/alu_op; go to EXEC.
  - EXEC: each cycle is one ALU pass. alu_out is sampled at the closing edge, and the next pass's inputs are loaded on that same edge. After the last pass, capture rsp_* and go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE and clear rsp_valid.
- Pass sequences (N = number of passes):
  - ADD/SUB/NAND/OR: 1 pass with (a, b), op 00/01/10/11.
  - CMP: 1 SUB pass with (a, b); rsp_data = a−b; rsp_wb=0.
  - XOR: N=4, all NAND.
    - t = a⊼b
    - u = a⊼t
    - v = b⊼t
    - r = u⊼v
  - SHL: acc=a.
    - k≥1: k ADD passes with (acc, acc), acc←alu_out; N=k.
    - k=0: one ADD pass with (a, 0x0000); N=1.
  - NOP: 1 pass with op 00, inputs 0x0000; rsp_data=0, rsp_wb=0, rsp_zero=1.
- Arithmetic is modulo 2^16. Carries are discarded, and SHL shifts bits out of bit 15.
- rsp_zero:
  - SUB/CMP: alu_zero sampled on the pass.
  - All other ops: (result == 0), computed locally. alu_zero is ignored outside SUB passes.
- alu_in1/alu_in2/alu_op hold their last values outside EXEC.

## Timing
- Request accepted at edge T. Passes occupy cycles T+1..T+N. rsp_valid rises after edge T+N+1.
  - 1-pass ops: 2-cycle latency.
  - XOR: 5-cycle latency.
  - SHL: max(k,1)+1 cycles.
- req_ready = (state == IDLE). There is no overlap: a new request cannot be accepted in the same cycle rsp_valid drops; it is accepted from the next IDLE cycle.
- rsp_data, rsp_zero and rsp_wb hold stable while rsp_valid=1 && !rsp_ready. Unlimited backpressure is allowed.
- Reset values, effective immediately on rst_n low:
  - state=IDLE, so req_ready=1.
  - rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_wb=0.
  - alu_in1=0, alu_in2=0, alu_op=00.
  - Pass counter and temporaries = 0.
- Reset in EXEC or RESP aborts the operation; no response is ever produced for it.
- Request inputs are ignored while req_ready=0.

## Test plan
- ADD 0x1234 + 0x0FFF, accepted at T → rsp_valid after T+2, data 0x2233, zero 0, wb 1. Wrap case: 0xFFFF + 0x0001 → data 0x0000, zero 1.
- SUB 0x00AA − 0x00AA → data 0x0000, zero 1 (from alu_zero). CMP 0x0005 vs 0x0003 → data 0x0002, zero 0, wb 0.
- XOR 0xF0F0 ^ 0x0FF0 → alu_op = 10,10,10,10 over 4 consecutive cycles; rsp at T+5 with data 0xFF00, zero 0.
- SHL:
  - a=0x0003, b=0x0004 → 4 ADD passes, data 0x0030.
  - a=0x8001, b=0x0010 (k=0) → 1 pass, data 0x8001.
  - a=0x8001, k=1 → data 0x0002.
- Backpressure: hold rsp_ready=0 for 3 cycles after an OR 0x00F0|0x0F00 → data stays 0x0FF0, req_ready=0 throughout; the next request is accepted the cycle after the handshake.
- Assert rst_n low during XOR pass 2 → every output returns to its reset value asynchronously; no response appears. A following NAND 0xFFFF⊼0xFFFF → data 0x0000, zero 1.
